// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions: instruction field positions, PC step and fetch FSM states.
package cpu_defs;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 11;
  localparam int FLAG_BIT = 10;
  localparam int IMM_MSB  = 9;
  localparam int IMM_LSB  = 0;
  localparam int PC_STEP  = 2;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: async reset to RESET_PC, halfword-aligned load, +PC_STEP increment with wrap.
module pc_reg
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Load wins over increment; targets are forced even because instructions are halfword aligned.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i & ~ADDR_W'(1);
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding memory request, single instruction register,
// valid/ready hand-off to decode and PC redirect handling (including draining a stale response).
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [4:0]         OPCODE,
  output logic               flagbit,
  output logic [9:0]         IMM,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr
);

  if_state_e          state_q, state_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [ADDR_W-1:0]  tgt_q, tgt_d;
  logic               pcLoad;
  logic               pcInc;
  logic [ADDR_W-1:0]  pcLoadAddr;
  logic [ADDR_W-1:0]  pc;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .load_i     (pcLoad),
    .load_addr_i(pcLoadAddr),
    .inc_i      (pcInc),
    .pc_o       (pc)
  );

  // The PC only moves once the outstanding request is resolved, so it doubles as the fetch address.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    tgt_d      = tgt_q;
    pcLoad     = 1'b0;
    pcInc      = 1'b0;
    pcLoadAddr = redirect_addr;
    unique case (state_q)
      IF_FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          pcLoad = redirect;
        end else if (mem_ack) begin
          if (redirect) begin
            pcLoad = 1'b1;
          end else begin
            instr_d = mem_rdata;
            ipc_d   = pc;
            pcInc   = 1'b1;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = IF_HOLD;
          end
        end else if (redirect) begin
          tgt_d   = redirect_addr;
          state_d = IF_DRAIN;
        end
      end
      IF_HOLD: begin
        if (redirect || instr_ready) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          pcLoad  = redirect;
          state_d = IF_FETCH;
        end
      end
      IF_DRAIN: begin
        if (redirect) begin
          tgt_d = redirect_addr;
        end
        // A redirect arriving together with the ack is the newest target.
        if (mem_ack) begin
          pcLoad     = 1'b1;
          pcLoadAddr = redirect ? redirect_addr : tgt_q;
          req_d      = 1'b1;
          state_d    = IF_FETCH;
        end
      end
      default: begin
        state_d = IF_FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IF_FETCH;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = pc;
  assign instr_valid = valid_q;
  assign instr_pc    = ipc_q;
  assign OPCODE      = instr_q[OP_MSB:OP_LSB];
  assign flagbit     = instr_q[FLAG_BIT];
  assign IMM         = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: each scenario task drives the memory and decode sides
// and compares the outputs against hand-computed values.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [4:0]  OPCODE;
  logic        flagbit;
  logic [9:0]  IMM;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_addr;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .RESET_PC(16'h0000)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .OPCODE       (OPCODE),
    .flagbit      (flagbit),
    .IMM          (IMM),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release, where the first request is up.
  task automatic doReset();
    Reset         = 1'b1;
    mem_ack       = 1'b0;
    mem_rdata     = 16'h0000;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 16'h0000;
    repeat (2) tick();
    Reset = 1'b0;
    tick();
  endtask

  // Called in the cycle the request rises; returns in the cycle after the ack.
  task automatic applyResponse(input int lat, input logic [15:0] data);
    repeat (lat) tick();
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    mem_ack = 1'b0; mem_rdata = 16'h0000; instr_ready = 1'b0;
    redirect = 1'b0; redirect_addr = 16'h0000;
    repeat (2) tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %h expected 0", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 0000", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %h expected 0", instr_valid); end
    checks++; if ({OPCODE, flagbit, IMM} !== 16'h0000) begin errors++; $display("[TB] FAIL rst_fields: got %h expected 0000", {OPCODE, flagbit, IMM}); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL rst_ipc: got %h expected 0000", instr_pc); end
    Reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rel_req_low: got %h expected 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL first_addr: got %h expected 0000", mem_addr); end
  endtask

  task automatic test_sequential();
    doReset();
    instr_ready = 1'b1;
    applyResponse(1, 16'h0000);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid0: got %h expected 1", instr_valid); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL seq_ipc0: got %h expected 0000", instr_pc); end
    checks++; if ({OPCODE, flagbit} !== 6'h00) begin errors++; $display("[TB] FAIL seq_op0: got %h expected 00", {OPCODE, flagbit}); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL seq_req_drop: got %h expected 0", mem_req); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid_pulse: got %h expected 0", instr_valid); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_req1: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 16'h0002) begin errors++; $display("[TB] FAIL seq_addr1: got %h expected 0002", mem_addr); end
    applyResponse(1, 16'h0000);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid1: got %h expected 1", instr_valid); end
    checks++; if (instr_pc !== 16'h0002) begin errors++; $display("[TB] FAIL seq_ipc1: got %h expected 0002", instr_pc); end
    tick();
    checks++; if (mem_addr !== 16'h0004) begin errors++; $display("[TB] FAIL seq_addr2: got %h expected 0004", mem_addr); end
  endtask

  task automatic test_hold();
    doReset();
    instr_ready = 1'b0;
    applyResponse(1, 16'h0C00);
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid[%0d]: got %h expected 1", i, instr_valid); end
      checks++; if ({OPCODE, flagbit, IMM} !== {5'b00001, 1'b1, 10'h000}) begin errors++; $display("[TB] FAIL hold_fields[%0d]: got %h expected 0c00", i, {OPCODE, flagbit, IMM}); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req[%0d]: got %h expected 0", i, mem_req); end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_valid: got %h expected 0", instr_valid); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL hold_release_req: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 16'h0002) begin errors++; $display("[TB] FAIL hold_release_addr: got %h expected 0002", mem_addr); end
  endtask

  task automatic test_drain();
    doReset();
    instr_ready = 1'b1;
    tick();
    tick();
    redirect = 1'b1; redirect_addr = 16'h0030;
    tick();
    redirect_addr = 16'h0040;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL drain_req: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL drain_addr: got %h expected 0000", mem_addr); end
    tick();
    redirect = 1'b0;
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL drain_addr_ack: got %h expected 0000", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_discard: got %h expected 0", instr_valid); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL drain_newreq: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 16'h0040) begin errors++; $display("[TB] FAIL drain_target: got %h expected 0040", mem_addr); end
    applyResponse(1, 16'h1234);
    checks++; if (instr_pc !== 16'h0040) begin errors++; $display("[TB] FAIL drain_ipc: got %h expected 0040", instr_pc); end
    checks++; if ({OPCODE, flagbit, IMM} !== {5'b00010, 1'b0, 10'h234}) begin errors++; $display("[TB] FAIL drain_fields: got %h expected 1234", {OPCODE, flagbit, IMM}); end
  endtask

  task automatic test_redirect_on_ack();
    doReset();
    instr_ready = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h7777; redirect = 1'b1; redirect_addr = 16'h0200;
    tick();
    mem_ack = 1'b0; redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ackredir_valid: got %h expected 0", instr_valid); end
    checks++; if (mem_addr !== 16'h0200) begin errors++; $display("[TB] FAIL ackredir_addr: got %h expected 0200", mem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ackredir_stale: got %h expected 0", instr_valid); end
  endtask

  task automatic test_redirect_hold_ready();
    doReset();
    instr_ready = 1'b0;
    applyResponse(1, 16'h0400);
    instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 16'h0081;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL hr_accept: got %h expected 1", instr_valid); end
    tick();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL hr_valid: got %h expected 0", instr_valid); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL hr_req: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 16'h0080) begin errors++; $display("[TB] FAIL hr_addr: got %h expected 0080", mem_addr); end
    applyResponse(1, 16'h0000);
    checks++; if (instr_pc !== 16'h0080) begin errors++; $display("[TB] FAIL hr_ipc: got %h expected 0080", instr_pc); end
  endtask

  task automatic test_wrap();
    doReset();
    instr_ready = 1'b0;
    applyResponse(1, 16'h0000);
    redirect = 1'b1; redirect_addr = 16'hFFFE;
    tick();
    redirect = 1'b0;
    checks++; if (mem_addr !== 16'hFFFE) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected fffe", mem_addr); end
    applyResponse(1, 16'hA800);
    checks++; if (OPCODE !== 5'b10101) begin errors++; $display("[TB] FAIL wrap_op: got %h expected 15", OPCODE); end
    checks++; if (instr_pc !== 16'hFFFE) begin errors++; $display("[TB] FAIL wrap_ipc: got %h expected fffe", instr_pc); end
    instr_ready = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL wrap_req: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_next: got %h expected 0000", mem_addr); end
  endtask

  task automatic test_reset_midfetch();
    doReset();
    instr_ready = 1'b0;
    applyResponse(1, 16'hF955);
    checks++; if (OPCODE !== 5'b11111) begin errors++; $display("[TB] FAIL mid_op: got %h expected 1f", OPCODE); end
    redirect = 1'b1; redirect_addr = 16'h0100;
    tick();
    redirect = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_pending: got %h expected 1", mem_req); end
    Reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_req_async: got %h expected 0", mem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid_async: got %h expected 0", instr_valid); end
    checks++; if (OPCODE !== 5'b00000) begin errors++; $display("[TB] FAIL mid_op_async: got %h expected 00", OPCODE); end
    Reset = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart_req: got %h expected 1", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL mid_restart_addr: got %h expected 0000", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_drain();
    test_redirect_on_ack();
    test_redirect_hold_ready();
    test_wrap();
    test_reset_midfetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
